// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART: register offsets,
// CON bit positions and the common 2-bit serial FSM state encoding.
package uart_pkg;

   localparam logic [31:0] TXD_OFF = 32'd0;
   localparam logic [31:0] RXD_OFF = 32'd4;
   localparam logic [31:0] CON_OFF = 32'd8;

   localparam int CON_TX_IRQ_EN = 0;
   localparam int CON_RX_IRQ_EN = 1;
   localparam int CON_TX_DONE   = 2;
   localparam int CON_RX_DONE   = 3;
   localparam int CON_TX_BUSY   = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   function automatic logic [31:0] zext8(input logic [7:0] b);
      return {24'd0, b};
   endfunction

endpackage

// File: rtl/uart_bus_responder_if.sv
// MEM-stage load/store bus between the CPU (master) and a peripheral (slave).
interface uart_bus_responder_if;

   logic        MemRd;
   logic        MemWr;
   logic [31:0] Address;
   logic [31:0] WriteData;
   logic [31:0] ReadData;
   logic        hit;

   modport master (output MemRd, MemWr, Address, WriteData, input ReadData, hit);
   modport slave  (input MemRd, MemWr, Address, WriteData, output ReadData, hit);

endinterface

// File: rtl/uart_tx_fsm.sv
// UART transmitter: 1 start bit, 8 data bits LSB first, 1 stop bit,
// each held for CLKS_PER_BIT clocks. done_pulse fires on the edge leaving STOP.
module uart_tx_fsm
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] byte_in,
   output logic       busy,
   output logic       done_pulse,
   output logic       tx
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

   uart_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             tx_q, tx_d;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         tx_q    <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         tx_q    <= tx_d;
      end
   end

   always_ff @(posedge clk) begin
      shift_q <= shift_d;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      done_pulse = 1'b0;
      case (state_q)
         ST_IDLE: begin
            cnt_d = '0;
            bit_d = '0;
            if (start) begin
               shift_d = byte_in;
               state_d = ST_START;
            end
         end
         ST_START: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               state_d = ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d   = '0;
               shift_d = shift_q >> 1;
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (cnt_q == CNT_LAST) begin
               cnt_d      = '0;
               state_d    = ST_IDLE;
               done_pulse = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Line level is registered from the next state so uart_tx is glitch-free.
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = shift_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   assign busy = (state_q != ST_IDLE);
   assign tx   = tx_q;

endmodule

// File: rtl/uart_bus_responder.sv
// Memory-mapped UART on the MEM-stage bus: TXD/RXD/CON registers, RX
// deserialiser with 2-flop synchroniser, TX via uart_tx_fsm, level IRQ.
module uart_bus_responder
   import uart_pkg::*;
#(
   parameter int          CLKS_PER_BIT = 10417,
   parameter logic [31:0] BASE_ADDR    = 32'h40000018
) (
   input  logic                 clk,
   input  logic                 reset,
   uart_bus_responder_if.slave  bus,
   input  logic                 uart_rx,
   output logic                 uart_tx,
   output logic                 irqout
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

   logic hit_txd, hit_rxd, hit_con;
   logic wr_txd, wr_con, rd_con;
   logic tx_start, tx_busy, tx_done_pulse;
   logic unused_wdata;

   logic [7:0] txd_q, txd_d, rxd_q, rxd_d;
   logic [1:0] irq_en_q, irq_en_d;
   logic       tx_done_q, tx_done_d, rx_done_q, rx_done_d;
   logic       irq_q, irq_d;
   logic       rx_s1_q, rx_s2_q, rx_prev_q;

   uart_state_e      rx_state_q, rx_state_d;
   logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]       rx_bit_q, rx_bit_d;
   logic [7:0]       rx_shift_q, rx_shift_d;
   logic             rx_load;
   logic [31:0]      con_word;

   assign hit_txd = (bus.Address == BASE_ADDR + TXD_OFF);
   assign hit_rxd = (bus.Address == BASE_ADDR + RXD_OFF);
   assign hit_con = (bus.Address == BASE_ADDR + CON_OFF);
   assign bus.hit = hit_txd | hit_rxd | hit_con;

   // A simultaneous load and store is treated as a store only.
   assign wr_txd   = bus.MemWr & hit_txd;
   assign wr_con   = bus.MemWr & hit_con;
   assign rd_con   = bus.MemRd & ~bus.MemWr & hit_con;
   assign tx_start = wr_txd & ~tx_busy;
   assign unused_wdata = ^bus.WriteData[31:8];

   uart_tx_fsm #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
      .clk        (clk),
      .reset      (reset),
      .start      (tx_start),
      .byte_in    (bus.WriteData[7:0]),
      .busy       (tx_busy),
      .done_pulse (tx_done_pulse),
      .tx         (uart_tx)
   );

   always_comb begin
      con_word                = '0;
      con_word[CON_TX_IRQ_EN] = irq_en_q[0];
      con_word[CON_RX_IRQ_EN] = irq_en_q[1];
      con_word[CON_TX_DONE]   = tx_done_q;
      con_word[CON_RX_DONE]   = rx_done_q;
      con_word[CON_TX_BUSY]   = tx_busy;
   end

   always_comb begin
      bus.ReadData = '0;
      if (hit_txd)      bus.ReadData = zext8(txd_q);
      else if (hit_rxd) bus.ReadData = zext8(rxd_q);
      else if (hit_con) bus.ReadData = con_word;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         txd_q      <= '0;
         rxd_q      <= '0;
         irq_en_q   <= '0;
         tx_done_q  <= 1'b0;
         rx_done_q  <= 1'b0;
         irq_q      <= 1'b0;
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= ST_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
      end else begin
         txd_q      <= txd_d;
         rxd_q      <= rxd_d;
         irq_en_q   <= irq_en_d;
         tx_done_q  <= tx_done_d;
         rx_done_q  <= rx_done_d;
         irq_q      <= irq_d;
         rx_s1_q    <= uart_rx;
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
      end
   end

   always_ff @(posedge clk) begin
      rx_shift_q <= rx_shift_d;
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_load    = 1'b0;
      case (rx_state_q)
         ST_IDLE: begin
            rx_cnt_d = '0;
            rx_bit_d = '0;
            if (!rx_s2_q && rx_prev_q) rx_state_d = ST_START;
         end
         ST_START: begin
            // Half a bit in: a line back high means the edge was a glitch.
            if (rx_cnt_q == CNT_HALF) begin
               rx_cnt_d   = '0;
               rx_state_d = rx_s2_q ? ST_IDLE : ST_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
               if (rx_bit_q == 3'd7) rx_state_d = ST_STOP;
               else                  rx_bit_d   = rx_bit_q + 1'b1;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            if (rx_cnt_q == CNT_LAST) begin
               rx_cnt_d   = '0;
               rx_state_d = ST_IDLE;
               rx_load    = rx_s2_q;
            end else begin
               rx_cnt_d = rx_cnt_q + 1'b1;
            end
         end
         default: rx_state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      txd_d    = tx_start ? bus.WriteData[7:0] : txd_q;
      rxd_d    = rx_load ? rx_shift_q : rxd_q;
      irq_en_d = wr_con ? bus.WriteData[1:0] : irq_en_q;
      tx_done_d = tx_done_q;
      rx_done_d = rx_done_q;
      if (rd_con) begin
         tx_done_d = 1'b0;
         rx_done_d = 1'b0;
      end
      // Set events take priority over a same-edge clear by a CON load.
      if (tx_done_pulse) tx_done_d = 1'b1;
      if (rx_load)       rx_done_d = 1'b1;
      irq_d = (irq_en_d[0] & tx_done_d) | (irq_en_d[1] & rx_done_d);
   end

   assign irqout = irq_q;

endmodule

// File: tb/tb_uart_bus_responder.sv
// Scoreboard bench for uart_bus_responder: directed bus/serial stimulus
// queues expected values; a negedge monitor pops and compares them.
module tb_uart_bus_responder;

   localparam int          CPB   = 16;
   localparam logic [31:0] BASE  = 32'h40000018;
   localparam logic [31:0] A_TXD = BASE;
   localparam logic [31:0] A_RXD = BASE + 32'd4;
   localparam logic [31:0] A_CON = BASE + 32'd8;

   localparam int K_RD  = 0;
   localparam int K_HIT = 1;
   localparam int K_TX  = 2;
   localparam int K_IRQ = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic uart_rx = 1'b1;
   logic uart_tx;
   logic irqout;

   uart_bus_responder_if bus();

   uart_bus_responder #(.CLKS_PER_BIT(CPB), .BASE_ADDR(BASE)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus),
      .uart_rx (uart_rx),
      .uart_tx (uart_tx),
      .irqout  (irqout)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   failures = 0;

   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] act;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         case (e.kind)
            K_RD:    act = bus.ReadData;
            K_HIT:   act = {31'd0, bus.hit};
            K_TX:    act = {31'd0, uart_tx};
            default: act = {31'd0, irqout};
         endcase
         checks++;
         if (act !== e.val) begin
            failures++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", e.name, act, e.val);
         end
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic expect_out(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.kind = kind;
      e.val  = val;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
      bus.MemWr     = 1'b1;
      bus.Address   = addr;
      bus.WriteData = data;
      cyc();
      bus.MemWr = 1'b0;
   endtask

   task automatic bus_read(input logic [31:0] addr, input logic [31:0] exp, input string name);
      bus.MemRd   = 1'b1;
      bus.Address = addr;
      expect_out(K_RD, exp, name);
      cyc();
      bus.MemRd = 1'b0;
   endtask

   task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
      bus.Address = addr;
      expect_out(K_RD, exp, name);
      cyc();
   endtask

   task automatic check_hit(input logic [31:0] addr, input logic exp_hit, input string name);
      bus.Address = addr;
      expect_out(K_HIT, {31'd0, exp_hit}, name);
      if (!exp_hit) expect_out(K_RD, 32'd0, {name, "_rd"});
      cyc();
   endtask

   // Entered 'used' cycles after the TXD store edge; leaves one cycle after STOP ends.
   task automatic tx_frame_check(input logic [7:0] b, input int used, input bit inject_drop);
      logic [9:0] f;
      f = {1'b1, b, 1'b0};
      cyc(8 - used);
      expect_out(K_TX, {31'd0, f[0]}, "tx_start_bit");
      for (int i = 1; i < 10; i++) begin
         if (i == 1 && inject_drop) begin
            bus_write(A_TXD, 32'h0000_00FF);
            bus_read(A_TXD, {24'd0, b}, "txd_readback_busy");
            cyc(14);
         end else begin
            cyc(16);
         end
         expect_out(K_TX, {31'd0, f[i]}, $sformatf("tx_frame_bit%0d", i));
      end
      cyc(8);
   endtask

   task automatic rx_send(input logic [7:0] b, input logic stop_bit);
      logic [9:0] f;
      f = {stop_bit, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         uart_rx = f[i];
         cyc(CPB);
      end
      uart_rx = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.MemRd     = 1'b0;
      bus.MemWr     = 1'b0;
      bus.Address   = 32'd0;
      bus.WriteData = 32'd0;
      reset         = 1'b1;
      cyc(3);
      reset = 1'b0;
      cyc(50);

      expect_out(K_TX, 32'd1, "idle_tx");
      expect_out(K_IRQ, 32'd0, "idle_irq");
      bus_read(A_CON, 32'd0, "rst_con");
      bus_read(A_RXD, 32'd0, "rst_rxd");
      bus_read(A_TXD, 32'd0, "rst_txd");
      check_hit(A_TXD, 1'b1, "hit_txd");
      check_hit(A_RXD, 1'b1, "hit_rxd");
      check_hit(A_CON, 1'b1, "hit_con");
      check_hit(BASE - 32'd4, 1'b0, "miss_below");
      check_hit(BASE + 32'd12, 1'b0, "miss_above");
      check_hit(BASE + 32'd1, 1'b0, "miss_unaligned");

      // TX of 0x5A with both interrupts enabled and a dropped store mid-frame.
      bus_write(A_CON, 32'd3);
      bus_write(A_TXD, 32'hFFFF_FF5A);
      bus_read(A_CON, 32'h13, "con_tx_busy");
      tx_frame_check(8'h5A, 1, 1'b1);
      expect_out(K_IRQ, 32'd1, "irq_tx_done");
      bus_read(A_CON, 32'h07, "con_tx_done");
      expect_out(K_IRQ, 32'd0, "irq_after_con_read");
      peek(A_TXD, 32'h5A, "txd_readback_after");

      // RX of 0xC3.
      rx_send(8'hC3, 1'b1);
      cyc(4);
      expect_out(K_IRQ, 32'd1, "irq_rx_done");
      bus_read(A_RXD, 32'hC3, "rxd_c3");
      bus_read(A_CON, 32'h0B, "con_rx_done");
      expect_out(K_IRQ, 32'd0, "irq_rx_cleared");
      cyc();

      // Short low glitch must not start a reception.
      uart_rx = 1'b0;
      cyc(5);
      uart_rx = 1'b1;
      cyc(40);
      bus_read(A_CON, 32'h03, "con_after_glitch");

      // Framing error, then a good frame of the same byte.
      rx_send(8'h81, 1'b0);
      cyc(20);
      bus_read(A_CON, 32'h03, "con_after_frame_err");
      bus_read(A_RXD, 32'hC3, "rxd_kept_after_frame_err");
      rx_send(8'h81, 1'b1);
      cyc(4);
      bus_read(A_RXD, 32'h81, "rxd_81");
      bus_read(A_CON, 32'h0B, "con_rx_81");

      // Asynchronous reset during data bit 4 of 0x0F (bit 4 is 0).
      bus_write(A_TXD, 32'h0F);
      cyc(88);
      expect_out(K_TX, 32'd0, "tx_bit4_before_reset");
      cyc();
      reset       = 1'b1;
      bus.Address = A_CON;
      expect_out(K_TX, 32'd1, "tx_async_reset");
      expect_out(K_RD, 32'd0, "con_in_reset");
      expect_out(K_IRQ, 32'd0, "irq_in_reset");
      cyc(2);
      reset = 1'b0;
      cyc(2);

      bus_write(A_TXD, 32'h01);
      tx_frame_check(8'h01, 0, 1'b0);
      expect_out(K_IRQ, 32'd0, "irq_masked_tx_done");
      peek(A_CON, 32'h04, "con_tx_done_no_en");

      // Load and store together: store lands, flag clear is suppressed.
      bus.MemRd     = 1'b1;
      bus.MemWr     = 1'b1;
      bus.Address   = A_CON;
      bus.WriteData = 32'd2;
      cyc();
      bus.MemRd = 1'b0;
      bus.MemWr = 1'b0;
      peek(A_CON, 32'h06, "con_rdwr_store_wins");
      bus_read(A_CON, 32'h06, "con_read_after_rdwr");
      peek(A_CON, 32'h02, "con_cleared");

      for (int i = 0; i < 10 && sb.size() > 0; i++) cyc();
      if (sb.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_bus_responder.md
Name: uart_bus_responder

Overview:
- Memory-mapped UART peripheral that responds to the CPU MEM-stage load/store bus.
- It is the responder end of the Mem_MemRd/Mem_MemWr/address/write-data initiator interface.
- Serialises bytes written by software onto uart_tx and deserialises uart_rx into a readable register.
- Raises an interrupt request to the hazard/ID logic on TX-done or RX-done.
- Sits beside data memory and the LED/switch registers inside the MEM-stage peripheral decode.

Parameters:
- CLKS_PER_BIT, 10417: clock cycles per UART bit (100 MHz / 9600 baud). Must be at least 4.
- BASE_ADDR, 32'h40000018: byte address of UART_TXD. UART_RXD is at BASE+4; UART_CON is at BASE+8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- MemRd  in  1  load strobe from MEM stage
- MemWr  in  1  store strobe from MEM stage
- Address  in  32  byte address (ALU result)
- WriteData  in  32  store data (rt)
- ReadData  out  32  load data; 0 when the address does not hit this block
- hit  out  1  Address is one of the three UART registers
- uart_rx  in  1  serial input, idle high, asynchronous to clk
- uart_tx  out  1  serial output, idle high
- irqout  out  1  level interrupt request

Behaviour:
- Reset values: uart_tx=1, irqout=0, ReadData reflects cleared registers, TXD=0, RXD=0, CON=0, both FSMs in IDLE. Reset mid-frame aborts the frame immediately; no partial byte is kept.
- ReadData and hit are combinational from Address and register state, giving zero-latency loads in the same MEM cycle. All side effects occur on the rising clk edge.
- Register map:
  - TXD [7:0]: write sets TXD[7:0] and starts a transmission. Read returns the last written byte, zero-extended.
  - RXD [7:0]: read-only. Returns the last received byte, zero-extended.
  - CON bits: [0] tx_irq_en (R/W), [1] rx_irq_en (R/W), [2] tx_done (RO), [3] rx_done (RO), [4] tx_busy (RO). Bits [31:5] read 0. A store to CON writes only bits [1:0].
- Flag clearing: a load of CON clears tx_done and rx_done on that edge. If a flag-set event and a CON read happen on the same edge, the set wins.
- irqout = (tx_irq_en & tx_done) | (rx_irq_en & rx_done), registered.
- TX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - A TXD write in IDLE latches the byte and enters START on the next edge.
  - Each state holds for CLKS_PER_BIT cycles. DATA sends 8 bits, LSB first.
  - On leaving STOP: tx_done=1.
  - tx_busy=1 in every state except IDLE.
  - A TXD write while busy updates nothing and is dropped. Software must poll tx_busy.
- RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
  - uart_rx passes through a 2-flop synchroniser.
  - A falling edge in IDLE enters START. At CLKS_PER_BIT/2 the line is resampled; if it is high (glitch), return to IDLE.
  - DATA bits are sampled every CLKS_PER_BIT cycles at bit centre, LSB first.
  - In STOP at centre: if the line is high, load RXD and set rx_done. If it is low (framing error), discard the byte with no flag and return to IDLE.
  - A new byte arriving while rx_done is still set overwrites RXD; rx_done stays 1.
- MemRd and MemWr both high is illegal for the CPU. If it occurs, the write takes effect and the read side effects are suppressed.
- Counters are wide enough for CLKS_PER_BIT-1 and wrap only on the state transition.

Decomposition:
- Shared package uart_pkg: register offsets (TXD_OFF=0, RXD_OFF=4, CON_OFF=8), CON bit indices, and FSM state encodings (2-bit: IDLE, START, DATA, STOP).
- One sub-module, uart_tx_fsm: byte/start in, busy/done_pulse/tx out. The RX FSM, synchroniser and register file stay in the top module.

Test Plan:
- Reset, then idle 50 cycles -> uart_tx=1, irqout=0, loads of CON/RXD/TXD return 0, hit=1 only for 0x40000018/1C/20.
- CLKS_PER_BIT=16. Write CON=3, then write TXD=0x5A -> tx_busy=1 next cycle. uart_tx shows start 0, bits 0,1,0,1,1,0,1,0, stop 1, each 16 cycles. Then tx_done=1 and irqout=1. Load CON returns 0x07 and the next cycle irqout=0.
- During that frame, write TXD=0xFF -> frame still carries 0x5A and the TXD read-back stays 0x5A.
- Drive uart_rx with byte 0xC3 at 16 cycles/bit -> RXD reads 0xC3, rx_done=1. A 5-cycle low glitch alone produces no rx_done.
- Drive frame 0x81 with the stop bit low -> rx_done stays 0 and RXD is unchanged. A following valid 0x81 frame is accepted.
- Assert reset mid-TX at bit 4 -> uart_tx=1 asynchronously, tx_busy=0. After release, write TXD=0x01 and a full frame is sent.
